// File: rtl/rca_adder_pkg.sv
// Shared constants and types for the ripple-carry adder primitive.
package rca_adder_pkg;

    localparam int unsigned RCA_DEFAULT_N = 32;

    typedef struct packed {
        logic ovf;
        logic cout;
    } rca_flags_t;

endpackage

// File: rtl/rca_adder_if.sv
// Operand/result bundle for rca_adder; master drives operands, slave returns results.
interface rca_adder_if
    import rca_adder_pkg::*;
#(
    parameter int unsigned N = RCA_DEFAULT_N
) ();

    logic         in_valid;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] s;
    logic         ovf;
    logic         cout;
    logic         out_valid;

    modport master (
        output in_valid, a, b,
        input  s, ovf, cout, out_valid
    );

    modport slave (
        input  in_valid, a, b,
        output s, ovf, cout, out_valid
    );

endinterface

// File: rtl/rca_adder_full_adder.sv
// Single-bit full adder cell used to build the ripple-carry chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign sum  = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/rca_adder.sv
// Registered N-bit two's-complement adder: ripple-carry core plus one output register stage.
module rca_adder
    import rca_adder_pkg::*;
#(
    parameter int unsigned N = RCA_DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    rca_adder_if.slave   bus
);

    logic [N:0]   c;
    logic [N-1:0] sum;
    rca_flags_t   flags_comb;

    logic [N-1:0] s_q;
    rca_flags_t   flags_q;
    logic         valid_q;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_chain
        full_adder u_fa (
            .a    (bus.a[i]),
            .b    (bus.b[i]),
            .cin  (c[i]),
            .sum  (sum[i]),
            .cout (c[i+1])
        );
    end

    // Signed overflow: carry into the sign bit differs from carry out of it.
    always_comb begin
        flags_comb      = '0;
        flags_comb.ovf  = c[N] ^ c[N-1];
        flags_comb.cout = c[N];
    end

    // Results hold while idle so a/b garbage never reaches the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q     <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s_q     <= sum;
                flags_q <= flags_comb;
            end
        end
    end

    assign bus.s         = s_q;
    assign bus.ovf       = flags_q.ovf;
    assign bus.cout      = flags_q.cout;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_rca_adder.sv
// Scoreboard bench for rca_adder at N=32 and N=8 against an arithmetic reference model.
module tb_rca_adder;

    typedef struct {
        logic [31:0] s;
        logic        ovf;
        logic        cout;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int failures = 0;

    exp_t q32[$];
    exp_t q8[$];
    exp_t held32 = '{s: '0, ovf: 1'b0, cout: 1'b0};
    exp_t held8  = '{s: '0, ovf: 1'b0, cout: 1'b0};

    rca_adder_if #(.N(32)) bus32 ();
    rca_adder_if #(.N(8))  bus8 ();

    rca_adder #(.N(32)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus32)
    );

    rca_adder #(.N(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic, signed range test for overflow.
    function automatic exp_t model(int unsigned n, logic [31:0] a, logic [31:0] b);
        exp_t        r;
        longint      ua, ub, us, sa, sb, ssum, half, full;
        full = longint'(1) << n;
        half = longint'(1) << (n - 1);
        ua   = longint'(a) & (full - 1);
        ub   = longint'(b) & (full - 1);
        us   = ua + ub;
        r.s    = 32'(us % full);
        r.cout = (us >= full);
        sa   = (ua >= half) ? ua - full : ua;
        sb   = (ub >= half) ? ub - full : ub;
        ssum = sa + sb;
        r.ovf  = (ssum > half - 1) || (ssum < -half);
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard capture: record the expected response for every accepted operand pair.
    always @(posedge clk) begin
        if (rst_n) begin
            if (bus32.in_valid) q32.push_back(model(32, bus32.a, bus32.b));
            if (bus8.in_valid)  q8.push_back(model(8, 32'(bus8.a), 32'(bus8.b)));
        end
    end

    always @(negedge rst_n) begin
        q32.delete();
        q8.delete();
        held32 = '{s: '0, ovf: 1'b0, cout: 1'b0};
        held8  = '{s: '0, ovf: 1'b0, cout: 1'b0};
    end

    // Monitor: results due one cycle after capture; otherwise outputs must hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst32_valid", 32'(bus32.out_valid), 32'd0);
            chk("rst32_s", bus32.s, 32'd0);
            chk("rst8_valid", 32'(bus8.out_valid), 32'd0);
            chk("rst8_s", 32'(bus8.s), 32'd0);
        end else begin
            if (q32.size() > 0) begin
                held32 = q32.pop_front();
                chk("n32_valid", 32'(bus32.out_valid), 32'd1);
            end else begin
                chk("n32_idle_valid", 32'(bus32.out_valid), 32'd0);
            end
            chk("n32_s", bus32.s, held32.s);
            chk("n32_ovf", 32'(bus32.ovf), 32'(held32.ovf));
            chk("n32_cout", 32'(bus32.cout), 32'(held32.cout));

            if (q8.size() > 0) begin
                held8 = q8.pop_front();
                chk("n8_valid", 32'(bus8.out_valid), 32'd1);
            end else begin
                chk("n8_idle_valid", 32'(bus8.out_valid), 32'd0);
            end
            chk("n8_s", 32'(bus8.s), held8.s);
            chk("n8_ovf", 32'(bus8.ovf), 32'(held8.ovf));
            chk("n8_cout", 32'(bus8.cout), 32'(held8.cout));
        end
    end

    task automatic drive(logic v, logic [31:0] a32, logic [31:0] b32);
        @(posedge clk);
        #1;
        bus32.in_valid = v;
        bus32.a        = a32;
        bus32.b        = b32;
        bus8.in_valid  = v;
        bus8.a         = a32[7:0];
        bus8.b         = b32[7:0];
    endtask

    initial begin
        bus32.in_valid = 1'b0;
        bus32.a = '0;
        bus32.b = '0;
        bus8.in_valid = 1'b0;
        bus8.a = '0;
        bus8.b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, back to back.
        drive(1'b1, 32'd0, 32'd0);
        drive(1'b1, 32'd32, 32'd61);
        drive(1'b1, 32'd90, 32'd59);
        drive(1'b1, 32'd5, 32'hFFFF_FF9C);
        drive(1'b1, 32'hFFFF_FFFF, 32'd122);
        drive(1'b1, 32'h7FFF_FFFF, 32'd1);
        drive(1'b1, 32'h8000_0000, 32'h8000_0000);
        drive(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);

        // Valid, idle, valid: idle cycle must hold the previous result.
        drive(1'b1, 32'h1234_5678, 32'h0F0F_0F0F);
        drive(1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        drive(1'b1, 32'h7FFF_FFFF, 32'h0000_0001);

        // Asynchronous reset mid-cycle while the last result is showing.
        drive(1'b0, 32'd0, 32'd0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst32_s", bus32.s, 32'd0);
        chk("async_rst32_ovf", 32'(bus32.ovf), 32'd0);
        chk("async_rst32_cout", 32'(bus32.cout), 32'd0);
        chk("async_rst32_valid", 32'(bus32.out_valid), 32'd0);
        chk("async_rst8_s", 32'(bus8.s), 32'd0);
        chk("async_rst8_valid", 32'(bus8.out_valid), 32'd0);
        drive(1'b1, 32'h1111_1111, 32'h2222_2222);
        drive(1'b1, 32'h3333_3333, 32'h4444_4444);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic, mostly valid with occasional idle cycles.
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            if (i % 8 == 0) ra = 32'h8000_0000 | ra;
            if (i % 8 == 1) rb = rb & 32'h7FFF_FFFF;
            drive($urandom_range(0, 9) != 0, ra, rb);
        end

        drive(1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("drain32", 32'(q32.size()), 32'd0);
        chk("drain8", 32'(q8.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
